// File: rtl/bn_param_fold_1d.sv
// Folds BN statistics (gamma, beta, mean, inv_std) into per-channel Q2.14 scale/shift
// vectors for the affine stage, one channel per cycle through a two-stage pipeline.
module bn_param_fold_1d #(
  parameter int C         = 512,
  parameter int FRAC_BITS = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               done,
  output logic               busy,
  output logic               params_valid,
  output logic               sat_flag,
  input  logic signed [15:0] gamma     [0:C-1],
  input  logic signed [15:0] beta      [0:C-1],
  input  logic signed [15:0] mean      [0:C-1],
  input  logic signed [15:0] inv_std   [0:C-1],
  output logic signed [15:0] scale_out [0:C-1],
  output logic signed [15:0] shift_out [0:C-1]
);

  localparam int IW = $clog2(C);

  typedef logic signed [31:0] acc_t;
  typedef logic signed [15:0] data_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          v1;
  logic [IW-1:0] idx1;
  data_t         s1;

  acc_t  prod1, sh1, m2, t2;
  data_t s_next, shift_next;
  logic  ovf1, ovf2;

  function automatic data_t sat16(input acc_t v);
    if (v > 32'sd32767) return 16'sh7fff;
    if (v < -32'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

  function automatic logic ovf16(input acc_t v);
    return (v > 32'sd32767) || (v < -32'sd32768);
  endfunction

  always_comb begin
    prod1      = acc_t'(gamma[idx]) * acc_t'(inv_std[idx]);
    sh1        = prod1 >>> FRAC_BITS;
    s_next     = sat16(sh1);
    ovf1       = ovf16(sh1);
    // Stage 2 folds the mean through the already-saturated scale so shift matches scale_out.
    m2         = (acc_t'(mean[idx1]) * acc_t'(s1)) >>> FRAC_BITS;
    t2         = acc_t'(beta[idx1]) - m2;
    shift_next = sat16(t2);
    ovf2       = ovf16(t2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      v1           <= 1'b0;
      idx1         <= '0;
      s1           <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      params_valid <= 1'b0;
      sat_flag     <= 1'b0;
      for (int c = 0; c < C; c++) begin
        scale_out[c] <= '0;
        shift_out[c] <= '0;
      end
    end else begin
      done <= 1'b0;
      v1   <= (state == RUN);

      if (state == RUN) begin
        s1   <= s_next;
        idx1 <= idx;
        if (ovf1) sat_flag <= 1'b1;
      end

      if (v1) begin
        scale_out[idx1] <= s1;
        shift_out[idx1] <= shift_next;
        if (ovf2) sat_flag <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            idx          <= '0;
            busy         <= 1'b1;
            sat_flag     <= 1'b0;
            params_valid <= 1'b0;
          end
        end
        RUN: begin
          if (idx == IW'(C - 1)) state <= DRAIN;
          else idx <= idx + 1'b1;
        end
        DRAIN: state <= DONE;
        DONE: begin
          done         <= 1'b1;
          params_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bn_param_fold_1d.sv
// Self-checking bench for bn_param_fold_1d: directed and random folds compared
// edge by edge against a plain-arithmetic reference model.
module tb_bn_param_fold_1d;

  localparam int C = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic done, busy, params_valid, sat_flag;
  logic signed [15:0] gamma [0:C-1];
  logic signed [15:0] beta [0:C-1];
  logic signed [15:0] mean [0:C-1];
  logic signed [15:0] inv_std [0:C-1];
  logic signed [15:0] scale_out [0:C-1];
  logic signed [15:0] shift_out [0:C-1];

  int n_cmp = 0;
  int n_bad = 0;

  int vis_scale [C];
  int vis_shift [C];
  int tgt_scale [C];
  int tgt_shift [C];
  bit tgt_c1 [C];
  bit tgt_c2 [C];
  bit exp_pv;
  bit exp_sat;

  bn_param_fold_1d #(.C(C), .FRAC_BITS(14)) dut (
    .clk(clk), .rst(rst), .start(start),
    .done(done), .busy(busy), .params_valid(params_valid), .sat_flag(sat_flag),
    .gamma(gamma), .beta(beta), .mean(mean), .inv_std(inv_std),
    .scale_out(scale_out), .shift_out(shift_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs, input int expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Floor division by 2^14, done as integer division with a correction for negatives.
  function automatic int floor_q14(input int v);
    if (v >= 0) return v / 16384;
    return -((-v + 16383) / 16384);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic buildModel();
    for (int ch = 0; ch < C; ch++) begin
      int g, is, m, b, raw_s, t;
      g = gamma[ch]; is = inv_std[ch]; m = mean[ch]; b = beta[ch];
      raw_s = floor_q14(g * is);
      tgt_scale[ch] = clamp16(raw_s);
      tgt_c1[ch] = (raw_s != tgt_scale[ch]);
      t = b - floor_q14(m * tgt_scale[ch]);
      tgt_shift[ch] = clamp16(t);
      tgt_c2[ch] = (t != tgt_shift[ch]);
    end
  endtask

  task automatic checkAll(input string where, input int exp_done, input int exp_busy);
    for (int ch = 0; ch < C; ch++) begin
      checkOutput($sformatf("scale[%0d]@%s", ch, where), scale_out[ch], vis_scale[ch]);
      checkOutput($sformatf("shift[%0d]@%s", ch, where), shift_out[ch], vis_shift[ch]);
    end
    checkOutput($sformatf("done@%s", where), done, exp_done);
    checkOutput($sformatf("busy@%s", where), busy, exp_busy);
    checkOutput($sformatf("params_valid@%s", where), params_valid, exp_pv);
    checkOutput($sformatf("sat_flag@%s", where), sat_flag, exp_sat);
  endtask

  task automatic setAll(input int g, input int is, input int m, input int b);
    for (int ch = 0; ch < C; ch++) begin
      gamma[ch] = 16'(g); inv_std[ch] = 16'(is); mean[ch] = 16'(m); beta[ch] = 16'(b);
    end
  endtask

  // One fold. hold_last: last edge index (0 = accept edge) at which start is still high.
  // mid: extra start pulse seen at edge 2. tail=0 leaves start high to chain the next run.
  task automatic applyStimulus(input int hold_last, input bit mid, input bit tail);
    buildModel();
    if (start !== 1'b1) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk); #1;
    exp_sat = 1'b0;
    exp_pv  = 1'b0;
    checkAll("e0", 0, 1);
    start = (hold_last >= 1);
    for (int n = 1; n <= C + 3; n++) begin
      if (!tail && n == C + 3) break;
      @(posedge clk); #1;
      if (n - 1 < C && tgt_c1[n-1]) exp_sat = 1'b1;
      if (n >= 2 && n - 2 < C) begin
        vis_scale[n-2] = tgt_scale[n-2];
        vis_shift[n-2] = tgt_shift[n-2];
        if (tgt_c2[n-2]) exp_sat = 1'b1;
      end
      if (n == C + 2) exp_pv = 1'b1;
      checkAll($sformatf("e%0d", n), (n == C + 2) ? 1 : 0, (n <= C + 1) ? 1 : 0);
      start = ((n + 1) <= hold_last) || (mid && (n + 1) == 2);
    end
    start = !tail;
  endtask

  task automatic resetMidRun();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    for (int ch = 0; ch < C; ch++) begin
      vis_scale[ch] = 0;
      vis_shift[ch] = 0;
    end
    exp_pv  = 1'b0;
    exp_sat = 1'b0;
    checkAll("async_rst", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      checkAll($sformatf("post_rst%0d", n), 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    setAll(16384, 8192, 8192, 4096);
    for (int ch = 0; ch < C; ch++) begin
      vis_scale[ch] = 0;
      vis_shift[ch] = 0;
    end
    exp_pv = 1'b0;
    exp_sat = 1'b0;
    #12;
    checkAll("reset", 0, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] nominal fold");
    applyStimulus(0, 0, 1);

    $display("[TB] scale saturation");
    gamma[0] = 16'sd32767;  inv_std[0] = 16'sd32767;
    gamma[1] = -16'sd16384; inv_std[1] = 16'sd32767;
    applyStimulus(0, 0, 1);

    $display("[TB] shift saturation then nominal clear");
    setAll(32767, 32767, 32767, -32768);
    applyStimulus(0, 0, 1);
    setAll(16384, 8192, 8192, 4096);
    applyStimulus(0, 0, 1);

    $display("[TB] handshake: held start and mid-run pulse");
    applyStimulus(C + 2, 1, 1);
    applyStimulus(0, 1, 1);

    $display("[TB] back-to-back starts");
    applyStimulus(0, 0, 0);
    setAll(-8192, 16384, 4096, -100);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 1);

    $display("[TB] reset mid-run");
    resetMidRun();
    applyStimulus(0, 0, 1);

    $display("[TB] pipeline ordering");
    for (int ch = 0; ch < C; ch++) begin
      gamma[ch] = 16'(4096 * (ch + 1));
      inv_std[ch] = 16'sd16384;
      mean[ch] = 16'sd0;
      beta[ch] = 16'(ch);
    end
    applyStimulus(0, 0, 1);

    $display("[TB] random folds");
    for (int r = 0; r < 20; r++) begin
      for (int ch = 0; ch < C; ch++) begin
        gamma[ch]   = 16'($urandom());
        beta[ch]    = 16'($urandom());
        mean[ch]    = 16'($urandom());
        inv_std[ch] = ($urandom_range(0, 3) == 0) ? 16'sd32767 : 16'($urandom_range(0, 32767));
      end
      applyStimulus(($urandom_range(0, 3) == 0) ? C + 2 : 0, 1'($urandom_range(0, 1)),
                    (r == 19) ? 1'b1 : 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
